execute_writeback_stage: RTL and testbench
==========================================

Name: execute_writeback_stage

Overview:
- Consumes the registered decode/execute fields (opcode, func3, func7, r_reg1, r_reg2, wr_reg, immediate_data).
- Holds the architectural register file, performs the integer ALU operation and registers the result.
- Writes the result back into the register file one cycle later, with operand forwarding.
- Last stage of the pipeline; result and debug ports exist for observation and verification.

Parameters:
- WIDTH, 15, width of immediate_data from the decode stage
- DATA_W, 8, register and ALU data width (power of 2, at least 4)
- ADDR_W, 5, register index width; register file depth is 2^ADDR_W

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction opcode
- func3  input  3  function code
- func7  input  7  function code; bit 5 selects SUB/SRA
- r_reg1  input  5  source register 1 index
- r_reg2  input  5  source register 2 index
- wr_reg  input  5  destination register index
- immediate_data  input  WIDTH  immediate; arrives one cycle after the other fields of the same instruction
- result_out  output  DATA_W  registered ALU result
- result_reg  output  5  destination index of result_out
- result_valid  output  1  result_out holds a writing instruction
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  combinational register file read at dbg_addr; returns 0 for index 0

Behaviour:
- Reset: rst_n low asynchronously clears every register file entry, the aligned field registers (opcode field to 0000000 = bubble), result_out=0, result_reg=0 and result_valid=0. Reset asserted mid-operation discards all in-flight instructions.
- Alignment (edge k): opcode, func3, func7, r_reg1, r_reg2 and wr_reg are captured into aligned registers.
- Execute (cycle after edge k): operands use the aligned fields and the live immediate_data. The result is captured at edge k+1.
- Writeback: at edge k+2 the register file is written from result_out/result_reg when result_valid=1 and result_reg!=0.
- Index handling: only the low ADDR_W bits of indices are used. Index 0 always reads 0 and is never written.
- Immediate: imm = immediate_data sign-extended from bit WIDTH-1 to DATA_W. If WIDTH>DATA_W, the low DATA_W bits are used.
- R-type (opcode 0110011), per func3:
  - 000: ADD, or SUB when func7[5]=1
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when func7[5]=1
  - 110: OR
  - 111: AND
- I-type (opcode 0010011): same operation map with operand B = imm. func7[5] is honoured only for func3=101; ADDI never subtracts.
- Shifts: shift amount is the low log2(DATA_W) bits of operand B.
- Arithmetic: wraps modulo 2^DATA_W. SLT/SLTU produce 1 or 0.
- Any other opcode is a bubble: result_valid=0 at the next edge, result_out and result_reg hold their previous values, no writeback.
- Forwarding: when result_valid=1 and result_reg!=0, a source index matching result_reg takes result_out instead of the register file, so back-to-back dependent instructions need no stall. Sources that only match the entry written at the same edge read the file value, which is already updated.
- Simultaneous events: a writeback and a dbg_addr read of the same entry in one cycle return the old value until the edge.
- No stall or flush inputs: one instruction per cycle, result latency 1 cycle after alignment.

Test Plan:
- Reset: drive rst_n=0 mid-stream with result_valid=1 -> all outputs 0 immediately (asynchronous); dbg_data=0 for every address after release.
- ADDI chain: addi x1,x0,5 then addi x2,x0,-3 (imm=0x7FFD) -> result_out 0x05 then 0xFD; dbg_data x1=0x05, x2=0xFD after writeback.
- Forwarding: addi x3,x0,7 immediately followed by add x4,x3,x3 -> result_out=0x0E with no bubble; x4=0x0E.
- R-type sweep with x1=0x05, x2=0xFD:
  - sub x5,x1,x2 -> 0x08
  - slt x6,x2,x1 -> 1
  - sltu x6,x2,x1 -> 0
  - sra x7,x2,x1 (shamt 5) -> 0xFF
  - srl x7,x2,x1 -> 0x07
  - xor -> 0xF8; or -> 0xFD; and -> 0x05
- x0 and bubbles: addi x0,x0,9 -> result_valid=1, dbg_data[0]=0. Opcode 1100011 -> result_valid=0, no register changes.
- Wrap: x1=0xFF, addi x1,x1,1 -> 0x00; slli by imm 9 uses shamt 1.

Source files
------------

// File: rtl/execute_writeback_stage.sv
// Execute/writeback stage: aligned fields, integer ALU, register file
// with single-cycle writeback delay and result forwarding.
module execute_writeback_stage #(
  parameter int WIDTH  = 15,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [4:0]        r_reg1,
  input  logic [4:0]        r_reg2,
  input  logic [4:0]        wr_reg,
  input  logic [WIDTH-1:0]  immediate_data,
  output logic [DATA_W-1:0] result_out,
  output logic [4:0]        result_reg,
  output logic              result_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  logic [6:0]        a_opcode;
  logic [2:0]        a_func3;
  logic [6:0]        a_func7;
  logic [ADDR_W-1:0] a_rs1;
  logic [ADDR_W-1:0] a_rs2;
  logic [4:0]        a_rd;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu;
  logic [SH_W-1:0]   shamt;
  logic [ADDR_W-1:0] wa;
  logic              is_r;
  logic              is_i;
  logic              alt;
  logic              fwd;
  logic              unused_f7;

  if (WIDTH >= DATA_W) begin : g_trunc
    logic unused_imm;
    assign unused_imm = ^immediate_data;
    assign imm = immediate_data[DATA_W-1:0];
  end else begin : g_sext
    assign imm = {{(DATA_W-WIDTH){immediate_data[WIDTH-1]}},
                  immediate_data};
  end

  assign unused_f7 = ^{a_func7[6], a_func7[4:0]};
  assign is_r  = (a_opcode == OP_R);
  assign is_i  = (a_opcode == OP_I);
  assign wa    = ADDR_W'(result_reg);
  assign fwd   = result_valid && (wa != '0);

  // func7[5] flips ADD/SUB only for R-type; SRL/SRA for both.
  assign alt = a_func7[5] &&
               ((a_func3 == 3'b101) || (is_r && a_func3 == 3'b000));

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (a_rs1 != '0)
      op_a = (fwd && a_rs1 == wa) ? result_out : rf[a_rs1];
    if (a_rs2 != '0)
      op_b = (fwd && a_rs2 == wa) ? result_out : rf[a_rs2];
    if (is_i)
      op_b = imm;
  end

  assign shamt = op_b[SH_W-1:0];

  always_comb begin
    alu = '0;
    case (a_func3)
      3'b000: alu = alt ? op_a - op_b : op_a + op_b;
      3'b001: alu = op_a << shamt;
      3'b010: alu = DATA_W'($signed(op_a) < $signed(op_b));
      3'b011: alu = DATA_W'(op_a < op_b);
      3'b100: alu = op_a ^ op_b;
      3'b101: alu = alt ? DATA_W'($signed(op_a) >>> shamt)
                        : op_a >> shamt;
      3'b110: alu = op_a | op_b;
      3'b111: alu = op_a & op_b;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_opcode     <= '0;
      a_func3      <= '0;
      a_func7      <= '0;
      a_rs1        <= '0;
      a_rs2        <= '0;
      a_rd         <= '0;
      result_out   <= '0;
      result_reg   <= '0;
      result_valid <= 1'b0;
    end else begin
      a_opcode <= opcode;
      a_func3  <= func3;
      a_func7  <= func7;
      a_rs1    <= ADDR_W'(r_reg1);
      a_rs2    <= ADDR_W'(r_reg2);
      a_rd     <= wr_reg;
      unique case (1'b1)
        is_r, is_i: begin
          result_out   <= alu;
          result_reg   <= a_rd;
          result_valid <= 1'b1;
        end
        default: result_valid <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= '0;
    end else if (fwd) begin
      rf[wa] <= result_out;
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_execute_writeback_stage.sv
// Directed bench for execute_writeback_stage: instruction table with
// expected results, register file check, writeback/debug and reset cases.
module tb_execute_writeback_stage;

  localparam int WIDTH  = 15;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7S  = 7'b0100000;
  localparam int N = 21;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [4:0]        r_reg1;
  logic [4:0]        r_reg2;
  logic [4:0]        wr_reg;
  logic [WIDTH-1:0]  immediate_data;
  logic [DATA_W-1:0] result_out;
  logic [4:0]        result_reg;
  logic              result_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  int checks = 0;
  int errors = 0;

  execute_writeback_stage #(
    .WIDTH(WIDTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .func3(func3), .func7(func7),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .wr_reg(wr_reg),
    .immediate_data(immediate_data),
    .result_out(result_out), .result_reg(result_reg),
    .result_valid(result_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [14:0] imm;
    logic        ev;
    logic [7:0]  eo;
    logic [4:0]  er;
  } vec_t;

  vec_t tbl [N];
  logic [7:0] model [32];

  function automatic vec_t mk(
    input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic [14:0] imm, input logic ev, input logic [7:0] eo,
    input logic [4:0] er);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
    v.rd = rd; v.imm = imm; v.ev = ev; v.eo = eo; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd);
    opcode = op; func3 = f3; func7 = f7;
    r_reg1 = rs1; r_reg2 = rs2; wr_reg = rd;
  endtask

  initial begin
    tbl[0]  = mk(OP_I, 3'd0, 7'd0, 5'd0,  5'd0, 5'd1,  15'd5,    1, 8'h05, 5'd1);
    tbl[1]  = mk(OP_I, 3'd0, 7'd0, 5'd0,  5'd0, 5'd2,  15'h7FFD, 1, 8'hFD, 5'd2);
    tbl[2]  = mk(OP_I, 3'd0, 7'd0, 5'd0,  5'd0, 5'd3,  15'd7,    1, 8'h07, 5'd3);
    tbl[3]  = mk(OP_R, 3'd0, 7'd0, 5'd3,  5'd3, 5'd4,  15'd0,    1, 8'h0E, 5'd4);
    tbl[4]  = mk(OP_R, 3'd0, F7S,  5'd1,  5'd2, 5'd5,  15'd0,    1, 8'h08, 5'd5);
    tbl[5]  = mk(OP_R, 3'd2, 7'd0, 5'd2,  5'd1, 5'd6,  15'd0,    1, 8'h01, 5'd6);
    tbl[6]  = mk(OP_R, 3'd3, 7'd0, 5'd2,  5'd1, 5'd6,  15'd0,    1, 8'h00, 5'd6);
    tbl[7]  = mk(OP_R, 3'd5, F7S,  5'd2,  5'd1, 5'd7,  15'd0,    1, 8'hFF, 5'd7);
    tbl[8]  = mk(OP_R, 3'd5, 7'd0, 5'd2,  5'd1, 5'd7,  15'd0,    1, 8'h07, 5'd7);
    tbl[9]  = mk(OP_R, 3'd4, 7'd0, 5'd1,  5'd2, 5'd8,  15'd0,    1, 8'hF8, 5'd8);
    tbl[10] = mk(OP_R, 3'd6, 7'd0, 5'd1,  5'd2, 5'd9,  15'd0,    1, 8'hFD, 5'd9);
    tbl[11] = mk(OP_R, 3'd7, 7'd0, 5'd1,  5'd2, 5'd10, 15'd0,    1, 8'h05, 5'd10);
    tbl[12] = mk(OP_I, 3'd0, 7'd0, 5'd0,  5'd0, 5'd0,  15'd9,    1, 8'h09, 5'd0);
    tbl[13] = mk(OP_R, 3'd0, 7'd0, 5'd0,  5'd0, 5'd16, 15'd0,    1, 8'h00, 5'd16);
    tbl[14] = mk(7'b1100011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 15'h7FFF, 0, 8'h00, 5'd16);
    tbl[15] = mk(OP_I, 3'd0, F7S,  5'd0,  5'd0, 5'd11, 15'd1,    1, 8'h01, 5'd11);
    tbl[16] = mk(OP_I, 3'd1, 7'd0, 5'd1,  5'd0, 5'd12, 15'd9,    1, 8'h0A, 5'd12);
    tbl[17] = mk(OP_I, 3'd5, F7S,  5'd2,  5'd0, 5'd13, 15'd1,    1, 8'hFE, 5'd13);
    tbl[18] = mk(OP_R, 3'd0, F7S,  5'd0,  5'd1, 5'd14, 15'd0,    1, 8'hFB, 5'd14);
    tbl[19] = mk(OP_I, 3'd0, 7'd0, 5'd0,  5'd0, 5'd15, 15'h7FFF, 1, 8'hFF, 5'd15);
    tbl[20] = mk(OP_I, 3'd0, 7'd0, 5'd15, 5'd0, 5'd15, 15'd1,    1, 8'h00, 5'd15);

    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    for (int i = 0; i < N; i++)
      if (tbl[i].ev && tbl[i].rd != 5'd0) model[tbl[i].rd] = tbl[i].eo;

    rst_n = 1'b0;
    drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    immediate_data = '0;
    dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result_out", 32'(result_out), 32'd0);
    chk("reset result_reg", 32'(result_reg), 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk($sformatf("v%0d valid", c - 2), 32'(result_valid), 32'(tbl[c-2].ev));
        chk($sformatf("v%0d out", c - 2), 32'(result_out), 32'(tbl[c-2].eo));
        chk($sformatf("v%0d reg", c - 2), 32'(result_reg), 32'(tbl[c-2].er));
      end
      if (c < N)
        drive(tbl[c].op, tbl[c].f3, tbl[c].f7, tbl[c].rs1, tbl[c].rs2, tbl[c].rd);
      else
        drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
      immediate_data = (c >= 1 && c <= N) ? tbl[c-1].imm : 15'd0;
    end
    @(negedge clk);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = ADDR_W'(a);
      #1;
      chk($sformatf("regfile x%0d", a), 32'(dbg_data), 32'(model[a]));
    end

    // Writeback pending: debug read sees old value until the edge.
    drive(OP_I, 3'd0, 7'd0, 5'd0, 5'd0, 5'd20);
    @(negedge clk);
    drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    immediate_data = 15'h33;
    @(negedge clk);
    dbg_addr = 5'd20;
    chk("wb pending valid", 32'(result_valid), 32'd1);
    chk("wb pending out", 32'(result_out), 32'h33);
    chk("wb pending dbg old", 32'(dbg_data), 32'h00);
    @(negedge clk);
    chk("wb done dbg", 32'(dbg_data), 32'h33);

    // Asynchronous reset while a valid result is held.
    drive(OP_I, 3'd0, 7'd0, 5'd0, 5'd0, 5'd21);
    @(negedge clk);
    drive(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    immediate_data = 15'h44;
    @(negedge clk);
    chk("pre-reset valid", 32'(result_valid), 32'd1);
    dbg_addr = 5'd1;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(result_valid), 32'd0);
    chk("async reset out", 32'(result_out), 32'd0);
    chk("async reset reg", 32'(result_reg), 32'd0);
    chk("async reset x1", 32'(dbg_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset valid", 32'(result_valid), 32'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_addr = ADDR_W'(a);
      #1;
      chk($sformatf("post-reset x%0d", a), 32'(dbg_data), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
